// File: rtl/qnigma_sipo_ctrl_pkg.sv
// rtl/qnigma_sipo_ctrl_pkg.sv - shared state type and count-width helper for the SIPO controller
package qnigma_sipo_ctrl_pkg;

  typedef enum logic {FILL, HOLD} state_e;

  function automatic int cnt_w(input int length);
    return $clog2(length + 1);
  endfunction

endpackage

// File: rtl/qnigma_sipo.sv
// rtl/qnigma_sipo.sv - bare serial-in parallel-out shift register with synchronous clear
module qnigma_sipo #(
  parameter int WIDTH  = 8,
  parameter int LENGTH = 8,
  parameter int RIGHT  = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          shift_i,
  input  logic [WIDTH-1:0]              dat_i,
  output logic [LENGTH-1:0][WIDTH-1:0]  par_o
);

  logic [LENGTH-1:0][WIDTH-1:0] par_q;

  // Clear is synchronous: the controller drives it from rst | handoff,
  // and a combinational handoff term must never reach an async reset pin.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      par_q <= '0;
    end else if (shift_i) begin
      if (RIGHT == 0) begin
        par_q <= {par_q[LENGTH-2:0], dat_i};
      end else begin
        par_q <= {dat_i, par_q[LENGTH-1:1]};
      end
    end
  end

  assign par_o = par_q;

endmodule

// File: rtl/qnigma_sipo_ctrl.sv
// rtl/qnigma_sipo_ctrl.sv - FILL/HOLD sequencer around qnigma_sipo; QNIGMA_SIPO_CTRL_FLUSH_EN enables s_last early flush
module qnigma_sipo_ctrl
  import qnigma_sipo_ctrl_pkg::*;
#(
  parameter int  WIDTH  = 8,
  parameter int  LENGTH = 8,
  parameter int  RIGHT  = 0,
  localparam int CW     = cnt_w(LENGTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH-1:0]              s_dat,
  input  logic                          s_val,
  output logic                          s_rdy,
  input  logic                          s_last,
  output logic [LENGTH-1:0][WIDTH-1:0]  m_dat,
  output logic                          m_val,
  input  logic                          m_rdy,
  output logic [CW-1:0]                 m_cnt,
  output logic                          m_last
);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           last_q, last_d;
  logic           s_rdy_q, m_val_q;

  logic           accept, handoff, clear;
  logic [CW-1:0]  cnt_inc;
  logic           end_word, last_in;

  assign accept  = s_val & s_rdy_q;
  assign handoff = m_val_q & m_rdy;
  assign clear   = rst | handoff;
  assign cnt_inc = (cnt_q == CW'(LENGTH)) ? cnt_q : cnt_q + CW'(1);

`ifdef QNIGMA_SIPO_CTRL_FLUSH_EN
  assign end_word = accept & ((cnt_inc == CW'(LENGTH)) | s_last);
  assign last_in  = s_last;
`else
  logic unused_s_last;
  assign unused_s_last = s_last;
  assign end_word = accept & (cnt_inc == CW'(LENGTH));
  assign last_in  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      FILL: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (end_word) begin
            state_d = HOLD;
            last_d  = last_in;
          end
        end
      end
      HOLD: begin
        if (m_rdy) begin
          state_d = FILL;
          cnt_d   = '0;
          last_d  = 1'b0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Handshake flags are registered from the next state so neither
  // ready nor valid has a combinational path from the opposite side.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      s_rdy_q <= 1'b1;
      m_val_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      s_rdy_q <= (state_d == FILL);
      m_val_q <= (state_d == HOLD);
    end
  end

  qnigma_sipo #(
    .WIDTH  (WIDTH),
    .LENGTH (LENGTH),
    .RIGHT  (RIGHT)
  ) u_sipo (
    .clk_i   (clk),
    .rst_i   (clear),
    .shift_i (accept),
    .dat_i   (s_dat),
    .par_o   (m_dat)
  );

  assign s_rdy  = s_rdy_q;
  assign m_val  = m_val_q;
  assign m_cnt  = m_val_q ? cnt_q : '0;
  assign m_last = m_val_q & last_q;

endmodule

// File: tb/tb_qnigma_sipo_ctrl.sv
// tb/tb_qnigma_sipo_ctrl.sv - directed self-checking bench for qnigma_sipo_ctrl (LENGTH=4, both shift directions)
module tb_qnigma_sipo_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] s_dat;
  logic s_val, s_last, m_rdy;
  logic s_rdy0, s_rdy1, m_val0, m_val1, m_last0, m_last1;
  logic [3:0][7:0] m_dat0, m_dat1;
  logic [2:0] m_cnt0, m_cnt1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  qnigma_sipo_ctrl #(.WIDTH(8), .LENGTH(4), .RIGHT(0)) dut0 (
    .clk(clk), .rst(rst), .s_dat(s_dat), .s_val(s_val), .s_rdy(s_rdy0),
    .s_last(s_last), .m_dat(m_dat0), .m_val(m_val0), .m_rdy(m_rdy),
    .m_cnt(m_cnt0), .m_last(m_last0)
  );

  qnigma_sipo_ctrl #(.WIDTH(8), .LENGTH(4), .RIGHT(1)) dut1 (
    .clk(clk), .rst(rst), .s_dat(s_dat), .s_val(s_val), .s_rdy(s_rdy1),
    .s_last(s_last), .m_dat(m_dat1), .m_val(m_val1), .m_rdy(m_rdy),
    .m_cnt(m_cnt1), .m_last(m_last1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_val = 1'b0; s_last = 1'b0; s_dat = 8'h00; m_rdy = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    n_cmp++; if (m_val0 !== 1'b0) begin n_bad++; $display("FAIL reset_m_val got=%b exp=0", m_val0); end
    n_cmp++; if (s_rdy0 !== 1'b1) begin n_bad++; $display("FAIL reset_s_rdy got=%b exp=1", s_rdy0); end
    n_cmp++; if (m_cnt0 !== 3'd0) begin n_bad++; $display("FAIL reset_m_cnt got=%0d exp=0", m_cnt0); end
    n_cmp++; if (m_last0 !== 1'b0) begin n_bad++; $display("FAIL reset_m_last got=%b exp=0", m_last0); end
    n_cmp++; if (m_dat0 !== 32'h0) begin n_bad++; $display("FAIL reset_m_dat got=%h exp=0", m_dat0); end
  endtask

  task automatic test_full_word();
    logic [7:0] beats [4];
    int rdy_low;
    beats = '{8'h11, 8'h22, 8'h33, 8'h44};
    m_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_val = 1'b1; s_dat = beats[i];
      step();
      if (i < 3) begin
        n_cmp++; if (m_val0 !== 1'b0) begin n_bad++; $display("FAIL full_early_m_val beat=%0d got=%b exp=0", i, m_val0); end
      end
    end
    s_val = 1'b0;
    n_cmp++; if (m_val0 !== 1'b1) begin n_bad++; $display("FAIL full_m_val got=%b exp=1", m_val0); end
    n_cmp++; if (m_dat0 !== 32'h11223344) begin n_bad++; $display("FAIL full_r0_m_dat got=%h exp=11223344", m_dat0); end
    n_cmp++; if (m_dat1 !== 32'h44332211) begin n_bad++; $display("FAIL full_r1_m_dat got=%h exp=44332211", m_dat1); end
    n_cmp++; if (m_cnt0 !== 3'd4) begin n_bad++; $display("FAIL full_m_cnt got=%0d exp=4", m_cnt0); end
    n_cmp++; if (m_last0 !== 1'b0) begin n_bad++; $display("FAIL full_m_last got=%b exp=0", m_last0); end
    rdy_low = (s_rdy0 === 1'b0) ? 1 : 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (s_rdy0 !== 1'b1) rdy_low++;
    end
    n_cmp++; if (rdy_low !== 1) begin n_bad++; $display("FAIL full_s_rdy_low_cycles got=%0d exp=1", rdy_low); end
    n_cmp++; if (m_dat0 !== 32'h0) begin n_bad++; $display("FAIL full_clear_m_dat got=%h exp=0", m_dat0); end
  endtask

  task automatic test_backpressure();
    m_rdy = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      s_val = 1'b1; s_dat = 8'(i);
      step();
    end
    s_dat = 8'h55;
    for (int c = 0; c < 5; c++) begin
      n_cmp++; if (m_val0 !== 1'b1 || s_rdy0 !== 1'b0) begin n_bad++; $display("FAIL bp_hold cyc=%0d m_val=%b s_rdy=%b exp=1/0", c, m_val0, s_rdy0); end
      n_cmp++; if (m_dat0 !== 32'h01020304 || m_dat1 !== 32'h04030201) begin n_bad++; $display("FAIL bp_stable cyc=%0d got=%h/%h exp=01020304/04030201", c, m_dat0, m_dat1); end
      step();
    end
    m_rdy = 1'b1;
    step();
    n_cmp++; if (m_val0 !== 1'b0 || m_dat0 !== 32'h0) begin n_bad++; $display("FAIL bp_handoff m_val=%b m_dat=%h exp=0/0", m_val0, m_dat0); end
    step();
    n_cmp++; if (m_dat0 !== 32'h00000055 || m_dat1 !== 32'h55000000) begin n_bad++; $display("FAIL bp_next_beat got=%h/%h exp=00000055/55000000", m_dat0, m_dat1); end
    for (int i = 0; i < 3; i++) begin
      s_dat = 8'h66 + 8'(i * 17);
      step();
    end
    s_val = 1'b0;
    n_cmp++; if (m_val0 !== 1'b1 || m_dat0 !== 32'h55667788) begin n_bad++; $display("FAIL bp_second_word m_val=%b m_dat=%h exp=1/55667788", m_val0, m_dat0); end
    step();
  endtask

`ifdef QNIGMA_SIPO_CTRL_FLUSH_EN
  task automatic test_flush();
    m_rdy = 1'b0;
    s_val = 1'b1; s_dat = 8'hA5; s_last = 1'b1;
    step();
    s_val = 1'b0; s_last = 1'b0;
    n_cmp++; if (m_val0 !== 1'b1 || m_cnt0 !== 3'd1 || m_last0 !== 1'b1) begin n_bad++; $display("FAIL flush_ctl m_val=%b m_cnt=%0d m_last=%b exp=1/1/1", m_val0, m_cnt0, m_last0); end
    n_cmp++; if (m_dat0 !== 32'h000000A5 || m_dat1 !== 32'hA5000000) begin n_bad++; $display("FAIL flush_m_dat got=%h/%h exp=000000A5/A5000000", m_dat0, m_dat1); end
    m_rdy = 1'b1;
    step();
    for (int i = 1; i <= 4; i++) begin
      s_val = 1'b1; s_dat = 8'(i); s_last = (i == 4);
      step();
    end
    s_val = 1'b0; s_last = 1'b0;
    n_cmp++; if (m_dat0 !== 32'h01020304 || m_cnt0 !== 3'd4 || m_last0 !== 1'b1) begin n_bad++; $display("FAIL flush_full m_dat=%h m_cnt=%0d m_last=%b exp=01020304/4/1", m_dat0, m_cnt0, m_last0); end
    step();
  endtask
`else
  task automatic test_no_flush();
    m_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_val = 1'b1; s_dat = 8'hA1 + 8'(i); s_last = (i == 1);
      step();
      if (i < 3) begin
        n_cmp++; if (m_val0 !== 1'b0) begin n_bad++; $display("FAIL noflush_early beat=%0d m_val=%b exp=0", i, m_val0); end
      end
    end
    s_val = 1'b0; s_last = 1'b0;
    n_cmp++; if (m_val0 !== 1'b1 || m_last0 !== 1'b0 || m_cnt0 !== 3'd4) begin n_bad++; $display("FAIL noflush_word m_val=%b m_last=%b m_cnt=%0d exp=1/0/4", m_val0, m_last0, m_cnt0); end
    n_cmp++; if (m_dat0 !== 32'hA1A2A3A4) begin n_bad++; $display("FAIL noflush_m_dat got=%h exp=A1A2A3A4", m_dat0); end
    step();
  endtask
`endif

  task automatic test_async_reset();
    m_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_val = 1'b1; s_dat = 8'hE0 + 8'(i);
      step();
    end
    s_val = 1'b0;
    step();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (m_val0 !== 1'b0 || m_val1 !== 1'b0) begin n_bad++; $display("FAIL arst_m_val got=%b/%b exp=0/0", m_val0, m_val1); end
    step();
    rst = 1'b0;
    #1;
    n_cmp++; if (s_rdy0 !== 1'b1 || m_dat0 !== 32'h0) begin n_bad++; $display("FAIL arst_release s_rdy=%b m_dat=%h exp=1/0", s_rdy0, m_dat0); end
    m_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_val = 1'b1; s_dat = 8'h99 + 8'(i * 17);
      step();
    end
    s_val = 1'b0;
    n_cmp++; if (m_val0 !== 1'b1 || m_dat0 !== 32'h99AABBCC || m_cnt0 !== 3'd4) begin n_bad++; $display("FAIL arst_word m_val=%b m_dat=%h m_cnt=%0d exp=1/99AABBCC/4", m_val0, m_dat0, m_cnt0); end
    n_cmp++; if (m_dat1 !== 32'hCCBBAA99) begin n_bad++; $display("FAIL arst_r1_m_dat got=%h exp=CCBBAA99", m_dat1); end
    step();
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_backpressure();
`ifdef QNIGMA_SIPO_CTRL_FLUSH_EN
    test_flush();
`else
    test_no_flush();
`endif
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/qnigma_sipo_ctrl.md
# qnigma_sipo_ctrl

Sequencing controller for a serial-in parallel-out deserializer. Accepts a valid/ready stream of WIDTH-bit beats, shifts each accepted beat into an internal shift register, and presents the assembled LENGTH-beat word on a valid/ready output with a beat count. Sits between a byte/symbol stream source and word-wide consumers such as header parsers and key loaders. Owns the shift, clear and handoff sequencing that a bare shift register leaves to its user.

## Interface
- WIDTH, 8, bits per serial beat
- LENGTH, 8, beats per full word, ≥ 2
- RIGHT, 0, shift direction: 0 = new beat enters index 0; 1 = new beat enters index LENGTH-1
- CW (localparam), $clog2(LENGTH+1), count width

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- s_dat  in  WIDTH  serial beat
- s_val  in  1  beat valid
- s_rdy  out  1  controller can accept a beat
- s_last  in  1  final beat of the message; used only with flush enabled
- m_dat  out  [LENGTH-1:0][WIDTH-1:0]  assembled word
- m_val  out  1  word valid
- m_rdy  in  1  consumer accepts word
- m_cnt  out  CW  number of valid beats in m_dat (1..LENGTH)
- m_last  out  1  word ends the message

## Operation
- FSM states are FILL and HOLD. Reset state is FILL.
- FILL:
  - s_rdy=1, m_val=0.
  - An accepted beat (s_val&s_rdy) shifts into the register and increments cnt.
  - When the accepted beat makes cnt==LENGTH, go to HOLD with last_q=0.
- HOLD:
  - s_rdy=0, m_val=1.
  - m_dat, m_cnt and m_last are stable until m_rdy is sampled high.
  - On m_val&m_rdy: cnt→0, register cleared (synchronous clear pulse), back to FILL.
- Beat placement:
  - RIGHT=0: the first beat of a full word ends at index LENGTH-1 and the last at index 0.
  - RIGHT=1: the reverse.
- Partial words (flush only):
  - RIGHT=0: the k beats occupy [k-1:0].
  - RIGHT=1: the k beats occupy [LENGTH-1:LENGTH-k].
  - All remaining entries are zero.
- Simultaneous events:
  - In HOLD no beat is accepted, so s_val with m_rdy in HOLD causes only the handoff.
  - The beat is accepted the following cycle in FILL.
- Counter arithmetic: cnt is CW bits, saturates at LENGTH and never wraps; it reaches LENGTH only on entry to HOLD.

## Timing
- Reset values (asynchronous): state=FILL, cnt=0, m_val=0, s_rdy=1 after reset release, m_cnt=0, m_last=0.
  - The register is zeroed on the first clk edge while rst is high, because the clear is rst | handoff.
  - m_dat is undefined only before that first edge, while m_val=0.
- Latency: m_val rises in the cycle after the accepting edge of the final beat.
- Throughput: at most LENGTH beats per LENGTH+1 cycles, because HOLD lasts at least one cycle.
- m_rdy may be held high permanently. m_rdy is ignored in FILL.
- s_rdy does not depend combinationally on s_val. m_val does not depend combinationally on m_rdy.
- rst asserted mid-word or in HOLD immediately drops m_val and discards the word. There is no partial output.

## Configuration
- Macro: QNIGMA_SIPO_CTRL_FLUSH_EN.
- Defined:
  - An accepted beat with s_last=1 ends the word early and enters HOLD with m_cnt=cnt+1 and m_last=1.
  - s_last on the LENGTH-th beat gives a full word with m_last=1.
- Undefined:
  - s_last is ignored.
  - Words are emitted only when full. m_last is tied 0 and m_cnt=LENGTH whenever m_val=1.

## Structure
- Shared package qnigma_sipo_ctrl_pkg holds:
  - the state typedef (enum logic {FILL, HOLD});
  - a function cnt_w(LENGTH) that returns $clog2(LENGTH+1).
- Sub-module: one qnigma_sipo instance with the same WIDTH, LENGTH and RIGHT.
  - Its rst is driven by the controller's clear (rst | handoff).
  - Its shift is driven by s_val&s_rdy.
  - Its par_o drives m_dat directly.
- The controller contains only the FSM, cnt, last_q and the output muxing. It has no additional data storage.

## Test plan
- Full word, RIGHT=0, WIDTH=8, LENGTH=4, m_rdy=1: beats 0x11,0x22,0x33,0x44 back-to-back → one cycle after the 4th beat, m_dat={0x11,0x22,0x33,0x44} (index 3..0), m_cnt=4, m_last=0. s_rdy is low exactly one cycle.
- RIGHT=1, same beats → m_dat index 3..0 = {0x44,0x33,0x22,0x11}.
- Backpressure: m_rdy=0 for 5 cycles in HOLD with s_val=1 → s_rdy=0 and m_dat stable throughout. No beat is lost; the next beat is accepted the cycle after the handoff.
- Flush (macro defined), RIGHT=0: 0xA5 with s_last=1 as the first beat → m_dat=0x0000_00A5, m_cnt=1, m_last=1. Next word starts from zeroed contents.
- Without the macro, s_last=1 on the 2nd beat → no output until the 4th beat, and m_last=0.
- Async rst pulse in the middle of HOLD → m_val falls without a clk edge, state is FILL after release, and a following full word matches expected values with no stale data.
